sseg_scan_mux: RTL



---
 rtl/sseg_scan_mux.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: multiplexing scanner for a common-anode 7-segment display.
// Inputs pass through a double buffer (shadow, then active) so a frame never
// tears. One digit is selected per slot, and the first cycle of each slot is
// kept dark to prevent ghosting between digits.
// Build option: define SSEG_LZB_EN to blank leading zeros. Digit 0 is never
// blanked by this option.
module sseg_scan_mux #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    output logic [3:0]            scan_num,
    output logic                  scan_en,
    output logic [DIGITS-1:0]     an,
    output logic                  dp_n,
    output logic                  frame_strobe
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]          cnt, cnt_nxt;
    logic [IW-1:0]          idx, idx_nxt;
    logic [4*DIGITS-1:0]    shadow_digits, shadow_digits_nxt;
    logic [DIGITS-1:0]      shadow_dp, shadow_dp_nxt;
    logic [DIGITS-1:0]      shadow_blank, shadow_blank_nxt;
    logic [4*DIGITS-1:0]    active_digits, active_digits_nxt;
    logic [DIGITS-1:0]      active_dp, active_dp_nxt;
    logic [DIGITS-1:0]      active_blank, active_blank_nxt;
    logic                   pending, pending_nxt;
    logic                   frame_end;

    logic [DIGITS-1:0]      lz;
    logic [DIGITS-1:0]      blank_eff;
    logic [3:0]             num_nxt;
    logic                   sel_blank;
    logic                   sel_dp;
    logic                   lit;
    logic [DIGITS-1:0]      an_nxt;

    // Slot timing and double-buffer control.
    always_comb begin
        cnt_nxt           = cnt + CW'(1);
        idx_nxt           = idx;
        shadow_digits_nxt = shadow_digits;
        shadow_dp_nxt     = shadow_dp;
        shadow_blank_nxt  = shadow_blank;
        active_digits_nxt = active_digits;
        active_dp_nxt     = active_dp;
        active_blank_nxt  = active_blank;
        pending_nxt       = pending;
        frame_end         = (cnt == CNT_LAST) && (idx == IDX_LAST);

        if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end

        // A load that lands on the frame boundary goes straight to the active
        // buffer. It bypasses shadow and takes priority over any pending copy.
        if (frame_end) begin
            if (load) begin
                active_digits_nxt = digits_in;
                active_dp_nxt     = dp_in;
                active_blank_nxt  = blank_in;
                pending_nxt       = 1'b0;
            end else if (pending) begin
                active_digits_nxt = shadow_digits;
                active_dp_nxt     = shadow_dp;
                active_blank_nxt  = shadow_blank;
                pending_nxt       = 1'b0;
            end
        end else if (load) begin
            shadow_digits_nxt = digits_in;
            shadow_dp_nxt     = dp_in;
            shadow_blank_nxt  = blank_in;
            pending_nxt       = 1'b1;
        end
    end

`ifdef SSEG_LZB_EN
    // Leading-zero mask: digit k (k >= 1) is blanked when it and every digit
    // above it are zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz       = '0;
        for (int unsigned n = 0; n < DIGITS - 1; n++) begin
            all_zero = all_zero && (active_digits_nxt[4*(DIGITS-1-n) +: 4] == 4'd0);
            lz[DIGITS-1-n] = all_zero;
        end
    end
`else
    // Leading-zero suppression disabled.
    always_comb begin
        lz = '0;
    end
`endif

    // Next-cycle output values. These are computed from next-state values so
    // that the registered outputs line up with cnt and idx.
    always_comb begin
        blank_eff = active_blank_nxt | lz;
        num_nxt   = '0;
        sel_blank = 1'b0;
        sel_dp    = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IW'(i)) begin
                num_nxt   = active_digits_nxt[4*i +: 4];
                sel_blank = blank_eff[i];
                sel_dp    = active_dp_nxt[i];
            end
        end
        lit    = (cnt_nxt != '0) && !sel_blank;
        an_nxt = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (lit && (idx_nxt == IW'(i))) begin
                an_nxt[i] = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            idx           <= '0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            shadow_blank  <= '0;
            active_digits <= '0;
            active_dp     <= '0;
            active_blank  <= '0;
            pending       <= 1'b0;
            an            <= '1;
            scan_en       <= 1'b0;
            scan_num      <= '0;
            dp_n          <= 1'b1;
            frame_strobe  <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            idx           <= idx_nxt;
            shadow_digits <= shadow_digits_nxt;
            shadow_dp     <= shadow_dp_nxt;
            shadow_blank  <= shadow_blank_nxt;
            active_digits <= active_digits_nxt;
            active_dp     <= active_dp_nxt;
            active_blank  <= active_blank_nxt;
            pending       <= pending_nxt;
            an            <= an_nxt;
            scan_en       <= lit;
            scan_num      <= num_nxt;
            dp_n          <= lit ? ~sel_dp : 1'b1;
            frame_strobe  <= frame_end;
        end
    end

endmodule
